// File: rtl/mips_cpu_regfile_scheduler_pkg.sv
// Shared register-file constants and the writeback-port record type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: REG_ADDR_W/REG_DATA_W/REG_COUNT/REG_ZERO, reg_addr_t, reg_data_t, wb_t.
package mips_cpu_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int REG_COUNT  = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

    // One register-file write-port transaction.
    typedef struct packed {
        logic      en;
        reg_addr_t addr;
        reg_data_t data;
    } wb_t;

endpackage

// File: rtl/mips_cpu_regfile_scheduler_if.sv
// Bundle of writeback requests, issue-stage claims, decode hazard checks and the regfile write port.
// Latency: n/a (wiring only).
// Backpressure: req_ready / claim_ready are driven by the scheduler (slave side).
// Modports: master = execute/issue/decode side, slave = scheduler.
interface mips_cpu_regfile_scheduler_if #(
    parameter int N_REQ = 3
);
    import mips_cpu_pkg::*;

    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ*REG_ADDR_W-1:0] req_addr;
    logic [N_REQ*REG_DATA_W-1:0] req_data;
    logic [N_REQ-1:0]            req_ready;

    logic                        claim_valid;
    reg_addr_t                   claim_addr;
    logic                        claim_ready;

    reg_addr_t                   check_addr_a;
    reg_addr_t                   check_addr_b;
    logic                        hazard_a;
    logic                        hazard_b;

    reg_addr_t                   write_addr_c;
    logic                        write_enable_c;
    reg_data_t                   write_data_c;
    logic                        err_underflow;

    modport master (
        output req_valid, req_addr, req_data, claim_valid, claim_addr,
               check_addr_a, check_addr_b,
        input  req_ready, claim_ready, hazard_a, hazard_b,
               write_addr_c, write_enable_c, write_data_c, err_underflow
    );

    modport slave (
        input  req_valid, req_addr, req_data, claim_valid, claim_addr,
               check_addr_a, check_addr_b,
        output req_ready, claim_ready, hazard_a, hazard_b,
               write_addr_c, write_enable_c, write_data_c, err_underflow
    );

endinterface

// File: rtl/mips_cpu_regfile_scheduler_rr_arbiter.sv
// Round-robin arbiter: first requester after ptr (mod N) wins.
// Latency: purely combinational.
// Backpressure: grant is zero when no request is raised; never grants an idle requester.
// Ports: req (N) + ptr (last winner) -> grant (one-hot), idx (winner index), any (some grant).
module mips_cpu_rr_arbiter #(
    parameter int N     = 3,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin : search
        int j;
        j     = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        // Walk ptr+1, ptr+2, ... wrapping; the previous winner is visited last.
        for (int k = 1; k <= N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/mips_cpu_regfile_scheduler.sv
// Schedules the single regfile write port among N_REQ writeback sources and tracks pending writes.
// Latency: transfer in cycle T -> write_*_c valid in T+1; scoreboard retires at the end of T+1.
// Backpressure: one-hot req_ready (round-robin); claim_ready drops when a register's counter is full.
// Ports: clk, reset (sync, active-high), bus (slave modport: requests, claims, hazard checks, write port).
module mips_cpu_regfile_scheduler
    import mips_cpu_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int CNT_W = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    mips_cpu_regfile_scheduler_if.slave   bus
);

    localparam int               IDX_W   = $clog2(N_REQ);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // ---------------- arbitration ----------------
    logic [IDX_W-1:0] rr_ptr;
    logic [N_REQ-1:0] grant;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_any;
    logic             xfer;

    mips_cpu_rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

    assign bus.req_ready = reset ? '0 : grant;
    assign xfer          = gnt_any && !reset;

    reg_addr_t sel_addr;
    reg_data_t sel_data;

    always_comb begin
        sel_addr = REG_ZERO;
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_idx == IDX_W'(i)) begin
                sel_addr = bus.req_addr[i*REG_ADDR_W +: REG_ADDR_W];
                sel_data = bus.req_data[i*REG_DATA_W +: REG_DATA_W];
            end
        end
    end

    // ---------------- write-port register ----------------
    wb_t wb_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= IDX_W'(N_REQ - 1);
            wb_q   <= '0;
        end else begin
            // Writes to $0 are accepted but never reach the register file.
            wb_q.en <= xfer && (sel_addr != REG_ZERO);
            if (xfer) begin
                rr_ptr <= gnt_idx;
                if (sel_addr != REG_ZERO) begin
                    wb_q.addr <= sel_addr;
                    wb_q.data <= sel_data;
                end
            end
        end
    end

    assign bus.write_enable_c = wb_q.en;
    assign bus.write_addr_c   = wb_q.addr;
    assign bus.write_data_c   = wb_q.data;

    // ---------------- pending-write scoreboard ----------------
    // $0 has no storage: its count reads as zero forever.
    logic [CNT_W-1:0] cnt [1:REG_COUNT-1];
    logic             err_q;
    logic             claim_inc;
    logic             retire;
    logic             underflow_now;

    function automatic logic [CNT_W-1:0] cnt_at(input reg_addr_t a);
        if (a == REG_ZERO) return '0;
        return cnt[a];
    endfunction

    assign bus.claim_ready = !reset &&
                             ((bus.claim_addr == REG_ZERO) || (cnt_at(bus.claim_addr) != CNT_MAX));
    assign claim_inc       = bus.claim_valid && bus.claim_ready && (bus.claim_addr != REG_ZERO);

    // The write is retired on the same edge the register file commits it.
    assign retire          = wb_q.en;
    assign underflow_now   = retire && (cnt_at(wb_q.addr) == '0) &&
                             !(claim_inc && (bus.claim_addr == wb_q.addr));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 1; r < REG_COUNT; r++) cnt[r] <= '0;
            err_q <= 1'b0;
        end else begin
            for (int r = 1; r < REG_COUNT; r++) begin
                if (claim_inc && (bus.claim_addr == reg_addr_t'(r)) &&
                    !(retire && (wb_q.addr == reg_addr_t'(r)))) begin
                    cnt[r] <= cnt[r] + 1'b1;
                end else if (retire && (wb_q.addr == reg_addr_t'(r)) &&
                             !(claim_inc && (bus.claim_addr == reg_addr_t'(r))) &&
                             (cnt[r] != '0)) begin
                    cnt[r] <= cnt[r] - 1'b1;
                end
            end
            err_q <= err_q | underflow_now;
        end
    end

    assign bus.err_underflow = err_q;

    // No bypass: hazard holds until the counter drops, i.e. the cycle after the write lands.
    assign bus.hazard_a = (bus.check_addr_a != REG_ZERO) && (cnt_at(bus.check_addr_a) != '0);
    assign bus.hazard_b = (bus.check_addr_b != REG_ZERO) && (cnt_at(bus.check_addr_b) != '0);

endmodule
